// File: rtl/sipo_ctrl_pkg.sv
// sipo_ctrl_pkg: shared state encoding and default frame width for the SIPO frame controller
package sipo_ctrl_pkg;
  typedef enum logic {IDLE, COLLECT} state_t;
  localparam int WIDTH_DEF = 16;
endpackage

// File: rtl/sipo_shift_en.sv
// sipo_shift_en: enabled, clearable MSB-first shift register exposing its next-word value
module sipo_shift_en #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic [WIDTH-1:0] next_word
);
  logic [WIDTH-1:0] q;
  assign next_word = {q[WIDTH-2:0], din};
  // clear takes priority so a completing or aborted frame leaves no residue
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= next_word;
endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: collects serial bits into WIDTH-bit frames with a ready/valid holding register
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       serial_in,
  input  logic                       serial_valid,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       busy,
  output logic                       overrun,
  input  logic                       overrun_clr
);
  localparam int CW = $clog2(WIDTH+1);
  state_t state, state_nxt;
  logic accept, abort, complete, transfer, load, drop;
  logic [WIDTH-1:0] next_word;
  sipo_shift_en #(.WIDTH(WIDTH)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (accept),
    .clr       (abort || complete),
    .din       (serial_in),
    .next_word (next_word)
  );
  assign busy = state == COLLECT;
  // decode frame events; a completed word is dropped only when the holder is full and not draining
  always_comb begin
    accept    = busy && enable && serial_valid;
    abort     = busy && !enable;
    complete  = accept && (bit_cnt == CW'(WIDTH-1));
    transfer  = word_valid && word_ready;
    load      = complete && (!word_valid || word_ready);
    drop      = complete && word_valid && !word_ready;
    state_nxt = enable ? COLLECT : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // bit counter wraps to zero on completion and clears on abort
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bit_cnt <= '0;
    else if (abort || complete) bit_cnt <= '0;
    else if (accept) bit_cnt <= bit_cnt + CW'(1);
  // holding register and its valid flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_out   <= load ? next_word : word_out;
      word_valid <= load ? 1'b1 : transfer ? 1'b0 : word_valid;
    end
  // sticky overrun; a set on the same edge as a clear wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) overrun <= 1'b0;
    else overrun <= drop ? 1'b1 : overrun_clr ? 1'b0 : overrun;
endmodule
